stopwatch_run_ctrl: RTL and testbench

//   Run/pause/clear controller for the up/down BCD stopwatch counter chain
//   (0-9 and 5-0 digit counters with enable/load/clr). Turns single-cycle

---
 rtl/stopwatch_run_ctrl_pkg.sv | 22 ++
 rtl/stopwatch_run_ctrl_tick_prescaler.sv | 38 +++
 rtl/stopwatch_run_ctrl.sv | 117 +++++++++++
 tb/tb_stopwatch_run_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_run_ctrl_pkg.sv
// Shared definitions for the stopwatch run controller: state encodings and defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stopwatch_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // 100 ms per tick at 100 MHz
    localparam int unsigned TICK_DIV_DFLT = 10_000_000;
    localparam int unsigned TICK_W_DFLT   = 24;

    // Chain has nowhere left to count in the current direction
    function automatic logic is_terminal(input logic up, input logic at_zero, input logic at_max);
        return up ? at_max : at_zero;
    endfunction

endpackage

// File: rtl/stopwatch_run_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV prescaler with hold and synchronous clear; tick on the last count.
// Latency: tick is combinational from the count register, asserted while count==TICK_DIV-1 and run.
// Backpressure: none; run=0 holds the phase, clear forces zero.
module stopwatch_run_ctrl_tick_prescaler
    import stopwatch_run_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DFLT,
    parameter int unsigned TICK_W   = TICK_W_DFLT
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    assign tick = run && (count == LAST);

    // Count 0..TICK_DIV-1 while running, wrap exactly at LAST, hold otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/clear FSM turning button pulses into registered enable/clr/load strobes for the BCD chain.
// Latency: button sampled at edge N -> state and strobes valid after edge N; first enable TICK_DIV cycles after start.
// Backpressure: none; buttons are single-cycle pulses, priority clr > stop > start > dir.
module stopwatch_run_ctrl
    import stopwatch_run_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DFLT,
    parameter int unsigned TICK_W   = TICK_W_DFLT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clr,
    input  logic       btn_dir,
    input  logic       at_zero,
    input  logic       at_max,
    output logic       enable,
    output logic       up,
    output logic       clr,
    output logic       load,
    output logic [1:0] state,
    output logic       done
);

    state_t state_q, state_n;
    logic   up_n, enable_n, clr_n, load_n;
    logic   tick;
    logic   terminal;

    assign terminal = is_terminal(up, at_zero, at_max);
    assign state    = state_q;

    // Prescaler runs only in RUN; IDLE keeps it at zero so a start begins a fresh period
    stopwatch_run_ctrl_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .run   (state_q == ST_RUN),
        .clear (btn_clr || (state_q == ST_IDLE)),
        .tick  (tick)
    );

    // Next state, direction and strobes; the highest-priority button present is the only one acted on
    always_comb begin
        state_n  = state_q;
        up_n     = up;
        enable_n = 1'b0;
        clr_n    = 1'b0;
        load_n   = 1'b0;
        if (btn_clr) begin
            state_n = ST_IDLE;
            clr_n   = up;
            load_n  = !up;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_stop) begin
                        state_n = ST_IDLE;
                    end else if (btn_start) begin
                        state_n = terminal ? ST_DONE : ST_RUN;
                    end else if (btn_dir) begin
                        up_n = !up;
                    end
                end
                ST_RUN: begin
                    if (btn_stop) begin
                        state_n = ST_PAUSE;
                    end else if (tick) begin
                        if (terminal) begin
                            state_n = ST_DONE;
                        end else begin
                            enable_n = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (btn_stop) begin
                        state_n = ST_PAUSE;
                    end else if (btn_start) begin
                        state_n = ST_RUN;
                    end else if (btn_dir) begin
                        up_n = !up;
                    end
                end
                ST_DONE: begin
                    if (!btn_stop && !btn_start && btn_dir) begin
                        up_n = !up;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Register state, direction and all outputs; reset returns to IDLE counting up
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            up      <= 1'b1;
            enable  <= 1'b0;
            clr     <= 1'b0;
            load    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            up      <= up_n;
            enable  <= enable_n;
            clr     <= clr_n;
            load    <= load_n;
            done    <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Directed bench for stopwatch_run_ctrl with TICK_DIV=4; hand-computed expectations.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns after the next edge.
// Backpressure: n/a.
module tb_stopwatch_run_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_dir = 1'b0;
    logic       at_zero = 1'b0;
    logic       at_max = 1'b0;
    logic       enable, up, clr, load, done;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_run_ctrl #(
        .TICK_DIV (4),
        .TICK_W   (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clr   (btn_clr),
        .btn_dir   (btn_dir),
        .at_zero   (at_zero),
        .at_max    (at_max),
        .enable    (enable),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .state     (state),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present buttons for exactly one sampling edge: {start, stop, clr, dir}
    task automatic pulse(input logic s, input logic p, input logic c, input logic d);
        btn_start = s;
        btn_stop  = p;
        btn_clr   = c;
        btn_dir   = d;
        cyc();
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        btn_clr   = 1'b0;
        btn_dir   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  32'(state),  32'd0);
        chk({tag, "_up"},     32'(up),     32'd1);
        chk({tag, "_enable"}, 32'(enable), 32'd0);
        chk({tag, "_clr"},    32'(clr),    32'd0);
        chk({tag, "_load"},   32'(load),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
    endtask

    initial begin
        repeat (3) cyc();
        chk_reset_vals("por");
        reset = 1'b1;
        cyc();

        // Count down from IDLE, then pull reset while enable is high
        pulse(0, 0, 0, 1);
        chk("dir_idle_up", 32'(up), 32'd0);
        pulse(1, 0, 0, 0);
        chk("run_down_state", 32'(state), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("pre_rst_en_%0d", k), 32'(enable), (k == 4) ? 32'd1 : 32'd0);
        end
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        cyc();
        reset = 1'b1;

        // Fresh start: enables at 4, 8, 12 cycles after start
        pulse(1, 0, 0, 0);
        chk("start_state", 32'(state), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("run_en_%0d", k), 32'(enable), (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        pulse(0, 0, 1, 0);
        chk("clr_run_strobe", 32'(clr), 32'd1);
        chk("clr_run_load", 32'(load), 32'd0);
        chk("clr_run_state", 32'(state), 32'd0);
        cyc();
        chk("clr_one_cycle", 32'(clr), 32'd0);

        // Pause after 6 cycles keeps the prescaler phase
        pulse(1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("pause_pre_en_%0d", k), 32'(enable), (k == 4) ? 32'd1 : 32'd0);
        end
        pulse(0, 1, 0, 0);
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_en", 32'(enable), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("paused_en_%0d", k), 32'(enable), 32'd0);
        end
        pulse(0, 1, 0, 0);
        chk("stop_in_pause", 32'(state), 32'd2);
        pulse(1, 0, 0, 0);
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_en0", 32'(enable), 32'd0);
        cyc();
        chk("resume_en1", 32'(enable), 32'd0);
        cyc();
        chk("resume_en2", 32'(enable), 32'd1);

        // dir ignored in RUN; terminal at the tick goes DONE without enable
        pulse(0, 0, 0, 1);
        chk("dir_run_up", 32'(up), 32'd1);
        at_max = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("term_en_%0d", k), 32'(enable), 32'd0);
        end
        chk("term_state", 32'(state), 32'd3);
        chk("term_done", 32'(done), 32'd1);
        pulse(1, 0, 0, 0);
        chk("done_start_ign", 32'(state), 32'd3);
        chk("done_start_en", 32'(enable), 32'd0);
        at_max = 1'b0;
        pulse(0, 0, 1, 0);
        chk("done_clr_strobe", 32'(clr), 32'd1);
        chk("done_clr_load", 32'(load), 32'd0);
        chk("done_clr_state", 32'(state), 32'd0);
        chk("done_clr_done", 32'(done), 32'd0);

        // dir in IDLE then clr -> load strobe instead of clr
        pulse(0, 0, 0, 1);
        chk("dir_idle2_up", 32'(up), 32'd0);
        pulse(0, 0, 1, 0);
        chk("load_strobe", 32'(load), 32'd1);
        chk("load_no_clr", 32'(clr), 32'd0);
        cyc();
        chk("load_one_cycle", 32'(load), 32'd0);

        // Counting down from zero: start goes straight to DONE
        at_zero = 1'b1;
        pulse(1, 0, 0, 0);
        chk("zero_start_state", 32'(state), 32'd3);
        chk("zero_start_en", 32'(enable), 32'd0);
        cyc();
        chk("zero_start_en2", 32'(enable), 32'd0);
        at_zero = 1'b0;
        pulse(0, 0, 0, 1);
        chk("dir_done_up", 32'(up), 32'd1);
        chk("dir_done_state", 32'(state), 32'd3);
        pulse(0, 0, 1, 0);
        chk("clr_after_dir", 32'(clr), 32'd1);
        chk("clr_after_dir_ld", 32'(load), 32'd0);

        // Simultaneous buttons
        pulse(1, 1, 0, 0);
        chk("start_stop_idle", 32'(state), 32'd0);
        pulse(0, 0, 1, 1);
        chk("clr_dir_up", 32'(up), 32'd1);
        chk("clr_dir_strobe", 32'(clr), 32'd1);
        pulse(1, 0, 0, 0);
        cyc();
        cyc();
        pulse(1, 0, 1, 0);
        chk("clr_start_state", 32'(state), 32'd0);
        chk("clr_start_strobe", 32'(clr), 32'd1);
        chk("clr_start_en", 32'(enable), 32'd0);
        cyc();
        chk("clr_start_after", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
